// File: rtl/status_tx.sv
// status_tx: serial transmitter for FPGA-to-MBED status words.
// Shifts a latched parallel word out MSB-first on tx_data, one bit per
// four-phase handshake: tx_data settles, tx_confirm rises, MBED raises ack,
// tx_confirm falls, MBED drops ack, next bit.
// Optional feature: define STATUS_TX_PARITY_EN to append an even-parity bit
// (XOR of the latched word) after the LSB, sent with the same handshake.
module status_tx #(
    parameter int WIDTH          = 10,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word_in,
    input  logic             ack_in,
    output logic             tx_data,
    output logic             tx_confirm,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

`ifdef STATUS_TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BC_W = $clog2(NBITS + 1);
    localparam int SC_W = $clog2(SETUP_CYCLES + 1);
    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(NBITS - 1);
    localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SC_W-1:0]  setup_cnt_q, setup_cnt_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             tx_data_q, tx_data_d;
    logic             tx_confirm_q, tx_confirm_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             timeout_q, timeout_d;
    logic             ack_s1_q, ack_s_q;

    // Frame as it will be shifted out: the word, plus the parity bit if built.
    function automatic logic [NBITS-1:0] load_frame(input logic [WIDTH-1:0] w);
`ifdef STATUS_TX_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Two-flop synchronizer for the asynchronous MBED acknowledge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_s1_q <= 1'b0;
            ack_s_q  <= 1'b0;
        end else begin
            ack_s1_q <= ack_in;
            ack_s_q  <= ack_s1_q;
        end
    end

    // Handshake sequencing; all outputs are computed here and registered.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        setup_cnt_d  = setup_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        tx_data_d    = tx_data_q;
        tx_confirm_d = tx_confirm_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_data_d    = 1'b0;
                tx_confirm_d = 1'b0;
                busy_d       = 1'b0;
                if (load) begin
                    shift_d     = load_frame(word_in);
                    bit_cnt_d   = '0;
                    setup_cnt_d = '0;
                    tx_data_d   = word_in[WIDTH-1];
                    busy_d      = 1'b1;
                    state_d     = S_SETUP;
                end
            end

            S_SETUP: begin
                // The counter saturates so a long-held ack only delays the strobe.
                if (setup_cnt_q == SETUP_LAST && !ack_s_q) begin
                    tx_confirm_d = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = S_STROBE;
                end else if (setup_cnt_q != SETUP_LAST) begin
                    setup_cnt_d = setup_cnt_q + SC_W'(1);
                end
            end

            S_STROBE: begin
                if (ack_s_q) begin
                    tx_confirm_d = 1'b0;
                    wait_cnt_d   = '0;
                    state_d      = S_RELEASE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d    = 1'b1;
                    tx_confirm_d = 1'b0;
                    tx_data_d    = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end

            S_RELEASE: begin
                if (!ack_s_q) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        tx_data_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        shift_d     = shift_q << 1;
                        bit_cnt_d   = bit_cnt_q + BC_W'(1);
                        tx_data_d   = shift_q[NBITS-2];
                        setup_cnt_d = '0;
                        state_d     = S_SETUP;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d    = 1'b1;
                    tx_confirm_d = 1'b0;
                    tx_data_d    = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end

            S_DONE: begin
                tx_data_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any transfer at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            setup_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            tx_data_q    <= 1'b0;
            tx_confirm_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            setup_cnt_q  <= setup_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_confirm_q <= tx_confirm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_confirm = tx_confirm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: doc/status_tx.md
# status_tx

Serial transmitter for FPGA-to-MBED status words, the return path of the instruction link. It accepts a parallel status word, such as servo position or fault flags, from the core logic. It shifts the word out MSB-first over a data/confirm line pair and waits for a per-bit four-phase acknowledge from the MBED. It sits beside the instruction receiver and closes the bidirectional control loop with the microcontroller.

## Interface
- WIDTH, 10, status word width in bits
- SETUP_CYCLES, 4, clk cycles tx_data is held stable before tx_confirm rises (≥1)
- TIMEOUT_CYCLES, 50000, max clk cycles spent waiting for any single ack edge (≥4)

- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high
- load  input  1  start request; sampled only in IDLE
- word_in  input  WIDTH  status word; latched on the accepted load cycle
- ack_in  input  1  acknowledge from MBED; asynchronous, passes through 2-flop synchronizer → ack_s
- tx_data  output  1  current serial bit to MBED
- tx_confirm  output  1  bit-valid strobe to MBED
- busy  output  1  high from the cycle after the load is accepted until the transfer ends
- done  output  1  one-cycle pulse on successful completion
- timeout  output  1  one-cycle pulse when a transfer is aborted

## Operation
- NBITS = WIDTH, or WIDTH+1 with parity (see Configuration). bit_cnt width is clog2(NBITS+1); counters saturate and never wrap.
- The sync flops are included in reset. All outputs reset to 0, state goes to IDLE, and the shift register and counters clear.
- IDLE: if load=1, latch word_in into shift_reg, clear bit_cnt, drive tx_data=word_in[WIDTH-1], set busy=1, and go to SETUP. Otherwise tx_data=0 and tx_confirm=0.
- SETUP: count SETUP_CYCLES cycles with tx_data held. Advance only when the count has expired and ack_s=0. Stay in SETUP while ack_s is high, with no timeout counting here. On advance, set tx_confirm=1 and go to STROBE.
- STROBE: wait for ack_s=1. Then set tx_confirm=0 and go to RELEASE.
- RELEASE: wait for ack_s=0. If bit_cnt=NBITS-1, go to DONE. Otherwise shift left, increment bit_cnt, drive the next bit on tx_data, and go to SETUP.
- DONE: for one cycle, done=1, busy=0 and tx_data=0. Then go to IDLE.
- Timeout: a wait counter clears on entry to STROBE and to RELEASE. If it reaches TIMEOUT_CYCLES before the awaited ack edge:
  - timeout=1 for one cycle, with tx_confirm=0, tx_data=0 and busy=0;
  - go to IDLE; done is not asserted.
- load while busy is ignored, with no queueing. word_in changes after the load cycle have no effect.
- If reset and load are high together, reset wins.
- Reset mid-transfer aborts immediately: outputs return to 0 next edge, with no done and no timeout pulse.

## Timing
- Load accepted at edge N: busy=1 and tx_data=MSB after edge N.
- tx_confirm rises SETUP_CYCLES edges after tx_data changes, if ack_s was already low.
- ack_in rise → tx_confirm fall after 3 edges: 2 for the synchronizer, 1 for the registered output.
- ack_in fall → next tx_data after 3 edges.
- With MBED ack delay d clk cycles per edge, per-bit cost is SETUP_CYCLES + 2·(d+3) cycles.
- tx_data never changes while tx_confirm=1.
- done and timeout are mutually exclusive; each is exactly one cycle wide.

## Configuration
- STATUS_TX_PARITY_EN defined: NBITS=WIDTH+1. An even-parity bit (XOR of the latched word) is sent after the LSB using the same handshake.
- Not defined: NBITS=WIDTH and no parity logic is built.

## Test plan
- word_in=10'b1011001110, with the MBED model acking 5 cycles after each confirm edge → tx_data sequence 1,0,1,1,0,0,1,1,1,0 sampled at each tx_confirm rise. With parity, a trailing 0 follows. A single done pulse follows; busy=0 after.
- Setup check, SETUP_CYCLES=4 → tx_data stable ≥4 cycles before every tx_confirm rise, and unchanged while tx_confirm=1.
- TIMEOUT_CYCLES=100 and the MBED never acks bit 3 → timeout pulse exactly 100 cycles after the 4th tx_confirm rise. tx_confirm=0, busy=0, no done.
- load pulsed again during a transfer with word_in=10'h3FF → ignored; the original word completes. A load after done with 10'h3FF sends ten 1s, and with parity a trailing 0.
- reset asserted while in STROBE on bit 5 → all outputs 0 after the next edge. A new load afterward transmits from the MSB correctly.
- ack_in held high when load is applied → stays in SETUP with tx_confirm=0 until ack_in falls. Confirm then rises 3+ cycles later.
